pcs_tx_enc: RTL

- 10GBASE-R transmit PCS encode stage, directly downstream of the MAC transmit block.
- Each cycle it consumes the MAC's 64-bit word and control flags (idle/start/term/term_keep), builds a Clause-49 64b/66b block, scrambles the payload and registers a 66-bit block for the gearbox/serdes.
- It generates the MAC's `pcs_valid` backpressure, which pauses one cycle in every 33 for the 66:64 gearbox.

---
 rtl/pcs_tx_enc_pkg.sv | 51 +++++
 rtl/pcs_tx_enc_if.sv | 27 ++
 rtl/pcs_tx_enc_scrambler.sv | 40 ++++
 rtl/pcs_tx_enc.sv | 115 +++++++++++
 4 files changed

// File: rtl/pcs_tx_enc_pkg.sv
// Shared constants and helpers for the 10GBASE-R transmit encode path:
// sync headers, Clause-49 block types, control codes, scrambler taps.
package pcs_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_ERR   = 8'h1E;
    localparam logic [7:0] BT_START = 8'h78;
    localparam logic [7:0] BT_TERM [0:7] = '{
        8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF
    };

    localparam logic [6:0] CC_IDLE = 7'h00;
    localparam logic [6:0] CC_ERR  = 7'h1E;

    localparam int SCR_W     = 58;
    localparam int SCR_TAP_A = 38;
    localparam int SCR_TAP_B = 57;

    localparam int GEARBOX_PERIOD = 33;

    typedef enum logic [2:0] {
        BK_DATA,
        BK_IDLE,
        BK_START,
        BK_TERM,
        BK_ERR
    } blk_kind_t;

    typedef struct packed {
        logic       ok;
        logic [2:0] len;
    } keep_t;

    // A terminate keep is legal only as 0..7 contiguous low ones.
    function automatic keep_t keep_decode(input logic [7:0] keep);
        keep_t r;
        r.ok  = 1'b0;
        r.len = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (keep == 8'((1 << j) - 1)) begin
                r.ok  = 1'b1;
                r.len = 3'(j);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcs_tx_enc_if.sv
// MAC-to-PCS transmit word plus the encoded 66-bit block output.
// master = MAC side, slave = encoder side.
interface pcs_tx_enc_if #(
    parameter int DATA_W  = 64,
    parameter int KEEP_W  = DATA_W / 8,
    parameter int BLOCK_W = 66
);
    logic               pcs_valid_o;
    logic               ctrl_v_i;
    logic               idle_i;
    logic               start_i;
    logic               term_i;
    logic [KEEP_W-1:0]  term_keep_i;
    logic [DATA_W-1:0]  data_i;
    logic               block_v_o;
    logic [BLOCK_W-1:0] block_o;

    modport master (
        input  pcs_valid_o, block_v_o, block_o,
        output ctrl_v_i, idle_i, start_i, term_i, term_keep_i, data_i
    );

    modport slave (
        output pcs_valid_o, block_v_o, block_o,
        input  ctrl_v_i, idle_i, start_i, term_i, term_keep_i, data_i
    );
endinterface

// File: rtl/pcs_tx_enc_scrambler.sv
// Self-synchronous 1 + x^39 + x^58 scrambler, one W-bit word per enabled cycle.
// State always advances on the scrambled stream, even when bypassed.
module pcs_scrambler
    import pcs_pkg::*;
#(
    parameter bit BYPASS = 1'b0,
    parameter int W      = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [SCR_W-1:0] state;
    logic [SCR_W-1:0] state_nx;
    logic [W-1:0]     scr;

    // LSB first: each output bit is fed straight back into the shift history.
    always_comb begin
        state_nx = state;
        scr      = '0;
        for (int i = 0; i < W; i++) begin
            scr[i]   = din[i] ^ state_nx[SCR_TAP_A] ^ state_nx[SCR_TAP_B];
            state_nx = {state_nx[SCR_W-2:0], scr[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '1;
        end else if (en) begin
            state <= state_nx;
        end
    end

    assign dout = BYPASS ? din : scr;

endmodule

// File: rtl/pcs_tx_enc.sv
// 10GBASE-R transmit encode: builds a 64b/66b block from the MAC word, scrambles
// the payload and paces the MAC with a 1-in-33 gearbox pause.
module pcs_tx_enc
    import pcs_pkg::*;
#(
    parameter bit IS_10G   = 1'b1,
    parameter bit SCRAMBLE = 1'b1,
    parameter int DATA_W   = 64,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int BLOCK_W  = 66
) (
    input  logic        clk,
    input  logic        reset,
    pcs_tx_enc_if.slave bus
);

    logic               run;
    logic [5:0]         gb_cnt;
    logic [5:0]         gb_cnt_nx;
    logic               valid;
    logic [KEEP_W-1:0]  keep;
    keep_t              kd;
    blk_kind_t          kind;
    logic [DATA_W-1:0]  payload;
    logic [DATA_W-1:0]  scr_out;
    logic [1:0]         sync;
    logic               block_v;
    logic [BLOCK_W-1:0] block_q;

    // Counter holds at 0 on the first edge out of reset so the pause lands
    // on every 33rd cycle counted from the first accepting edge.
    always_comb begin
        if (!run || gb_cnt == 6'(GEARBOX_PERIOD - 1)) gb_cnt_nx = '0;
        else                                          gb_cnt_nx = gb_cnt + 6'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run    <= 1'b0;
            gb_cnt <= '0;
            valid  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (IS_10G) begin
                gb_cnt <= gb_cnt_nx;
                valid  <= (gb_cnt_nx != 6'(GEARBOX_PERIOD - 1));
            end else begin
                valid  <= 1'b1;
            end
        end
    end

    assign keep = bus.term_keep_i;

    always_comb begin
        kd   = keep_decode(keep);
        kind = BK_DATA;
        if (bus.ctrl_v_i) begin
            case ({bus.idle_i, bus.start_i, bus.term_i})
                3'b100:  kind = BK_IDLE;
                3'b010:  kind = BK_START;
                3'b001:  kind = kd.ok ? BK_TERM : BK_ERR;
                default: kind = BK_ERR;
            endcase
        end
    end

    // Trailing idle codes and reserved bits after a terminate are all zero.
    always_comb begin
        payload = bus.data_i;
        sync    = SYNC_CTRL;
        case (kind)
            BK_IDLE:  payload = {{8{CC_IDLE}}, BT_IDLE};
            BK_START: payload = {bus.data_i[DATA_W-1:8], BT_START};
            BK_TERM: begin
                payload      = '0;
                payload[7:0] = BT_TERM[kd.len];
                for (int b = 0; b < 7; b++) begin
                    if (3'(b) < kd.len) payload[8+8*b +: 8] = bus.data_i[8*b +: 8];
                end
            end
            BK_ERR:   payload = {{8{CC_ERR}}, BT_ERR};
            default: begin
                payload = bus.data_i;
                sync    = SYNC_DATA;
            end
        endcase
    end

    pcs_scrambler #(
        .BYPASS (!SCRAMBLE),
        .W      (DATA_W)
    ) u_scr (
        .clk   (clk),
        .reset (reset),
        .en    (valid),
        .din   (payload),
        .dout  (scr_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block_v <= 1'b0;
            block_q <= '0;
        end else begin
            block_v <= valid;
            if (valid) block_q <= {scr_out, sync};
        end
    end

    assign bus.pcs_valid_o = valid;
    assign bus.block_v_o   = block_v;
    assign bus.block_o     = block_q;

endmodule
